// File: rtl/index_mask_builder_pkg.sv
// Shared types and elaboration helpers for the index mask builder.
// The duplicate-detect option is controlled by INDEX_MASK_BUILDER_DUP_DETECT_EN.
package index_mask_builder_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // True when n is a usable vector width: a power of two, at least 2.
   function automatic bit is_valid_width(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/index_mask_builder_index_decoder.sv
// Combinational index-to-one-hot decoder; inverse of a leading-one index finder.
module index_decoder #(
   parameter int N = 32,
   localparam int M = $clog2(N)
) (
   input  logic [M-1:0] index_i,
   output logic [N-1:0] onehot_o
);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_bit
         assign onehot_o[gi] = (index_i == M'(gi));
      end
   endgenerate

endmodule

// File: rtl/index_mask_builder.sv
// Collects index beats of a frame into a bit mask with distinct-bit count.
// Define INDEX_MASK_BUILDER_DUP_DETECT_EN to enable the o_dup duplicate flag.
module index_mask_builder
   import index_mask_builder_pkg::*;
#(
   parameter int N = 32,
   localparam int M = $clog2(N)
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   input  logic [M-1:0] i_index,
   input  logic         i_last,
   output logic         o_ready,
   output logic [N-1:0] o_data,
   output logic [M:0]   o_count,
   output logic         o_valid,
   input  logic         i_ready,
   output logic         o_dup
);

   localparam logic [M:0] CNT_ONE = (M + 1)'(1);

   generate
      if (!is_valid_width(N)) begin : g_bad_width
         $error("index_mask_builder: N must be a power of 2 and at least 2");
      end
   endgenerate

   state_t       state_q, state_d;
   logic [N-1:0] mask_q, mask_d;
   logic [M:0]   count_q, count_d;
   logic [N-1:0] onehot;
   logic         accept;
   logic         hit;

   index_decoder #(.N(N)) u_decoder (
      .index_i  (i_index),
      .onehot_o (onehot)
   );

   assign accept = (state_q == ACCUM) && i_valid;
   assign hit    = |(mask_q & onehot);

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      count_d = count_q;
      case (state_q)
         ACCUM: begin
            if (accept) begin
               mask_d = mask_q | onehot;
               // A repeated index never advances the count, so it cannot exceed N.
               if (!hit) begin
                  count_d = count_q + CNT_ONE;
               end
               if (i_last) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (i_ready) begin
               state_d = ACCUM;
               mask_d  = '0;
               count_d = '0;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ACCUM;
         mask_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         count_q <= count_d;
      end
   end

`ifdef INDEX_MASK_BUILDER_DUP_DETECT_EN
   logic dup_q, dup_d;

   always_comb begin
      dup_d = dup_q;
      if (accept && hit) begin
         dup_d = 1'b1;
      end else if ((state_q == HOLD) && i_ready) begin
         dup_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dup_q <= 1'b0;
      end else begin
         dup_q <= dup_d;
      end
   end

   assign o_dup = dup_q;
`else
   assign o_dup = 1'b0;
`endif

   // Handshake outputs come from state only; no input-to-output paths.
   assign o_ready = (state_q == ACCUM);
   assign o_valid = (state_q == HOLD);
   assign o_data  = mask_q;
   assign o_count = count_q;

endmodule

// File: tb/tb_index_mask_builder.sv
// Directed self-checking bench for index_mask_builder at N=8.
module tb_index_mask_builder;

   localparam int N = 8;
   localparam int M = 3;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_valid;
   logic [M-1:0] i_index;
   logic         i_last;
   logic         o_ready;
   logic [N-1:0] o_data;
   logic [M:0]   o_count;
   logic         o_valid;
   logic         i_ready;
   logic         o_dup;

   int checks = 0;
   int errors = 0;

   index_mask_builder #(.N(N)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .i_index (i_index),
      .i_last  (i_last),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_count (o_count),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_dup   (o_dup)
   );

   always #5 i_clk = ~i_clk;

`ifdef INDEX_MASK_BUILDER_DUP_DETECT_EN
   localparam logic DUP_EXP = 1'b1;
`else
   localparam logic DUP_EXP = 1'b0;
`endif

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [M-1:0] idx, input logic last);
      i_valid = 1'b1;
      i_index = idx;
      i_last  = last;
      tick();
      $display("beat index=%0d last=%0b -> data=%b count=%0d valid=%0b", idx, last, o_data, o_count, o_valid);
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   task automatic test_reset();
      i_rst   = 1'b1;
      i_valid = 1'b1;
      i_index = 3'd3;
      i_last  = 1'b1;
      i_ready = 1'b0;
      tick();
      tick();
      checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 8'h00 || o_count !== 4'd0 || o_dup !== 1'b0) begin
         errors++;
         $display("FAIL reset: ready=%b valid=%b data=%h count=%0d dup=%b, required 1 0 00 0 0", o_ready, o_valid, o_data, o_count, o_dup);
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_rst   = 1'b0;
      tick();
      checks++;
      if (o_valid !== 1'b0 || o_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_beat_ignored: valid=%b data=%h, required 0 00", o_valid, o_data);
      end
   endtask

   task automatic test_basic();
      i_ready = 1'b1;
      send(3'd3, 1'b0);
      checks++;
      if (o_valid !== 1'b0 || o_data !== 8'h08 || o_count !== 4'd1) begin
         errors++;
         $display("FAIL basic_first: valid=%b data=%h count=%0d, required 0 08 1", o_valid, o_data, o_count);
      end
      send(3'd0, 1'b0);
      send(3'd7, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== 8'b1000_1001 || o_count !== 4'd3 || o_dup !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: valid=%b ready=%b data=%b count=%0d dup=%b, required 1 0 10001001 3 0", o_valid, o_ready, o_data, o_count, o_dup);
      end
      tick();
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== 8'h00 || o_count !== 4'd0) begin
         errors++;
         $display("FAIL basic_release: valid=%b ready=%b data=%h count=%0d, required 0 1 00 0", o_valid, o_ready, o_data, o_count);
      end
   endtask

   task automatic test_dup();
      i_ready = 1'b0;
      send(3'd5, 1'b0);
      send(3'd5, 1'b0);
      checks++;
      if (o_data !== 8'h20 || o_count !== 4'd1 || o_dup !== DUP_EXP) begin
         errors++;
         $display("FAIL dup_repeat: data=%h count=%0d dup=%b, required 20 1 %b", o_data, o_count, o_dup, DUP_EXP);
      end
      send(3'd2, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'b0010_0100 || o_count !== 4'd2 || o_dup !== DUP_EXP) begin
         errors++;
         $display("FAIL dup_result: valid=%b data=%b count=%0d dup=%b, required 1 00100100 2 %b", o_valid, o_data, o_count, o_dup, DUP_EXP);
      end
      i_ready = 1'b1;
      tick();
      checks++;
      if (o_valid !== 1'b0 || o_dup !== 1'b0 || o_count !== 4'd0) begin
         errors++;
         $display("FAIL dup_clear: valid=%b dup=%b count=%0d, required 0 0 0", o_valid, o_dup, o_count);
      end
   endtask

   task automatic test_hold();
      i_ready = 1'b0;
      for (int k = 0; k < N; k++) begin
         send(3'(k), (k == N - 1));
      end
      for (int c = 0; c < 3; c++) begin
         i_valid = 1'b1;
         i_index = 3'd0;
         i_last  = 1'b1;
         tick();
         checks++;
         if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== 8'hFF || o_count !== 4'd8) begin
            errors++;
            $display("FAIL hold_stable[%0d]: valid=%b ready=%b data=%h count=%0d, required 1 0 ff 8", c, o_valid, o_ready, o_data, o_count);
         end
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_ready = 1'b1;
      tick();
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== 8'h00 || o_count !== 4'd0) begin
         errors++;
         $display("FAIL hold_release: valid=%b ready=%b data=%h count=%0d, required 0 1 00 0", o_valid, o_ready, o_data, o_count);
      end
   endtask

   task automatic test_reset_mid();
      i_ready = 1'b1;
      send(3'd1, 1'b0);
      send(3'd4, 1'b0);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      checks++;
      if (o_data !== 8'h00 || o_count !== 4'd0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: data=%h count=%0d valid=%b ready=%b, required 00 0 0 1", o_data, o_count, o_valid, o_ready);
      end
      send(3'd6, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h40 || o_count !== 4'd1 || o_dup !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_single: valid=%b data=%h count=%0d dup=%b, required 1 40 1 0", o_valid, o_data, o_count, o_dup);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      i_ready = 1'b0;
      send(3'd1, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h02) begin
         errors++;
         $display("FAIL b2b_first: valid=%b data=%h, required 1 02", o_valid, o_data);
      end
      i_ready = 1'b1;
      i_valid = 1'b1;
      i_index = 3'd2;
      i_last  = 1'b1;
      tick();
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== 8'h00) begin
         errors++;
         $display("FAIL b2b_not_taken_in_hold: valid=%b ready=%b data=%h, required 0 1 00", o_valid, o_ready, o_data);
      end
      tick();
      $display("beat index=2 last=1 -> data=%b count=%0d valid=%0b", o_data, o_count, o_valid);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h04 || o_count !== 4'd1) begin
         errors++;
         $display("FAIL b2b_second: valid=%b data=%h count=%0d, required 1 04 1", o_valid, o_data, o_count);
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
      tick();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_release: valid=%b, required 0", o_valid);
      end
   endtask

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_index = '0;
      i_last  = 1'b0;
      i_ready = 1'b0;
      test_reset();
      test_basic();
      test_dup();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
